// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS data-memory responder: access widths and FSM states.
package mips_mem_pkg;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;
    localparam logic [1:0] W_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

endpackage

// File: rtl/mips_mem_lane.sv
// Little-endian lane logic: merges store data into a word and extracts/extends load data.
module mips_mem_lane
    import mips_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  width,
    input  logic [1:0]  offset,
    input  logic        sext,
    output logic [31:0] new_word,
    output logic [31:0] rdata
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        new_word = word;
        case (width)
            W_BYTE:  new_word[{offset, 3'b000} +: 8] = wdata[7:0];
            W_HALF:  new_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            W_WORD:  new_word = wdata;
            default: new_word = word;
        endcase
    end

    always_comb begin
        sel_byte = word[{offset, 3'b000} +: 8];
        sel_half = word[{offset[1], 4'b0000} +: 16];
        rdata    = '0;
        case (width)
            W_BYTE:  rdata = {{24{sext & sel_byte[7]}}, sel_byte};
            W_HALF:  rdata = {{16{sext & sel_half[15]}}, sel_half};
            W_WORD:  rdata = word;
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/mips_dmem_responder.sv
// Multi-cycle data-memory target with programmable wait states and valid/ready
// request and response channels.
module mips_dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_width,
    input  logic        req_sext,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          lat_we_q;
    logic          lat_sext_q;
    logic [1:0]    lat_width_q;
    logic [1:0]    lat_off_q;
    logic [AW-1:0] lat_idx_q;
    logic [31:0]   lat_wdata_q;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [31:0]   rsp_rdata_q;
    logic          rsp_error_q;

    logic          accept;
    logic          req_err;
    logic          do_access;
    logic          do_error;

    logic          acc_we;
    logic          acc_sext;
    logic [1:0]    acc_width;
    logic [1:0]    acc_off;
    logic [AW-1:0] acc_idx;
    logic [31:0]   acc_wdata;
    logic [31:0]   new_word;
    logic [31:0]   load_data;

    always_comb begin
        req_ready = (state_q == IDLE) && !reset;
        accept    = req_valid && req_ready;
        req_err   = (req_width == W_RSVD)
                  || ((req_width == W_HALF) && req_addr[0])
                  || ((req_width == W_WORD) && (req_addr[1:0] != 2'b00))
                  || ({1'b0, req_addr} >= ADDR_LIMIT);
    end

    // A zero-wait access happens on the acceptance edge, so it must use the live request.
    always_comb begin
        if (state_q == IDLE) begin
            acc_we    = req_we;
            acc_sext  = req_sext;
            acc_width = req_width;
            acc_off   = req_addr[1:0];
            acc_idx   = req_addr[AW+1:2];
            acc_wdata = req_wdata;
        end else begin
            acc_we    = lat_we_q;
            acc_sext  = lat_sext_q;
            acc_width = lat_width_q;
            acc_off   = lat_off_q;
            acc_idx   = lat_idx_q;
            acc_wdata = lat_wdata_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        do_access = 1'b0;
        do_error  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        do_error = 1'b1;
                        state_d  = RESP;
                    end else if (WAIT_CYCLES == 0) begin
                        do_access = 1'b1;
                        state_d   = RESP;
                    end else begin
                        cnt_d   = CW'(WAIT_CYCLES - 1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    do_access = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    mips_mem_lane u_lane (
        .word     (mem[acc_idx]),
        .wdata    (acc_wdata),
        .width    (acc_width),
        .offset   (acc_off),
        .sext     (acc_sext),
        .new_word (new_word),
        .rdata    (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (do_error) begin
                rsp_rdata_q <= '0;
                rsp_error_q <= 1'b1;
            end else if (do_access) begin
                rsp_rdata_q <= acc_we ? 32'h0 : load_data;
                rsp_error_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_we_q    <= req_we;
            lat_sext_q  <= req_sext;
            lat_width_q <= req_width;
            lat_off_q   <= req_addr[1:0];
            lat_idx_q   <= req_addr[AW+1:2];
            lat_wdata_q <= req_wdata;
        end
    end

    // Storage is never reset; reset only suppresses a pending write.
    always_ff @(posedge clk) begin
        if (!reset && do_access && acc_we) begin
            mem[acc_idx] <= new_word;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Randomized self-checking bench for mips_dmem_responder (WAIT_CYCLES=2 and 0 instances).
module tb_mips_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_width;
    logic        req_sext;
    logic        rsp_ready;
    int          sel;

    logic        v2, rr2, ready2, valid2, err2;
    logic        v0, rr0, ready0, valid0, err0;
    logic [31:0] rd2, rd0;

    logic        o_ready, o_valid, o_err;
    logic [31:0] o_rdata;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] ref_mem [2][64];

    always #5 clk = ~clk;

    assign v2      = req_valid & (sel == 0);
    assign rr2     = rsp_ready & (sel == 0);
    assign v0      = req_valid & (sel == 1);
    assign rr0     = rsp_ready & (sel == 1);
    assign o_ready = (sel == 1) ? ready0 : ready2;
    assign o_valid = (sel == 1) ? valid0 : valid2;
    assign o_err   = (sel == 1) ? err0   : err2;
    assign o_rdata = (sel == 1) ? rd0    : rd2;

    mips_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (v2),
        .req_ready (ready2),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_width (req_width),
        .req_sext  (req_sext),
        .rsp_valid (valid2),
        .rsp_ready (rr2),
        .rsp_rdata (rd2),
        .rsp_error (err2)
    );

    mips_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (v0),
        .req_ready (ready0),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_width (req_width),
        .req_sext  (req_sext),
        .rsp_valid (valid0),
        .rsp_ready (rr0),
        .rsp_rdata (rd0),
        .rsp_error (err0)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural memory: byte array, little-endian, errors decided from the access rules.
    task automatic model(input int s, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] width, input logic sext,
                         output logic [31:0] exp_rd, output logic exp_err);
        int n;
        logic [31:0] val;
        n = (width == 2'd0) ? 1 : (width == 2'd1) ? 2 : 4;
        exp_err = (width == 2'd3) || (width == 2'd1 && addr % 2 != 0)
               || (width == 2'd2 && addr % 4 != 0) || (addr >= 32'd4096);
        exp_rd = 32'h0;
        if (!exp_err && addr < 64) begin
            if (we) begin
                for (int i = 0; i < n; i++) ref_mem[s][addr + i] = wdata[8*i +: 8];
            end else begin
                val = 32'h0;
                for (int i = 0; i < n; i++) val = val | (32'(ref_mem[s][addr + i]) << (8 * i));
                if (sext && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8 * n));
                exp_rd = val;
            end
        end
    endtask

    task automatic txn(input int s, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] width, input logic sext,
                       input int stall);
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [31:0] held;
        int          n;
        int          lat;
        int          exp_lat;
        logic        stable;
        model(s, we, addr, wdata, width, sext, exp_rd, exp_err);
        exp_lat = exp_err ? 1 : ((s == 1) ? 1 : 3);
        @(negedge clk);
        sel       = s;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_width = width;
        req_sext  = sext;
        req_valid = 1'b1;
        rsp_ready = (stall == 0);
        n = 0;
        while (!o_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) begin
            check_val("accept_timeout", 32'(o_ready), 32'h1);
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        // Garbage while busy must be ignored.
        req_we    = $urandom % 2;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_width = $urandom % 4;
        lat = 1;
        while (!o_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_val("rsp_latency", 32'(lat), 32'(exp_lat));
        check_val("rsp_rdata", o_rdata, exp_rd);
        check_val("rsp_error", 32'(o_err), 32'(exp_err));
        if (stall > 0) begin
            held   = o_rdata;
            stable = 1'b1;
            for (int k = 0; k < stall; k++) begin
                @(negedge clk);
                if (!o_valid || o_ready || o_rdata !== held) stable = 1'b0;
            end
            check_val("stall_hold", 32'(stable), 32'h1);
            rsp_ready = 1'b1;
        end
        @(negedge clk);
        req_valid = 1'b0;
        check_val("rsp_drop", 32'(o_valid), 32'h0);
        check_val("back_idle", 32'(o_ready), 32'h1);
        rsp_ready = 1'b0;
    endtask

    task automatic rand_txn(input int s);
        logic [31:0] a;
        logic [1:0]  w;
        int          r;
        w = $urandom % 4;
        r = $urandom % 10;
        if (r == 0)      a = 32'h1000 + ($urandom % 32'h1000);
        else if (r == 1) a = $urandom | 32'h8000_0000;
        else begin
            a = $urandom % 64;
            if ($urandom % 4 != 0) begin
                if (w == 2'd1) a = a & ~32'h1;
                if (w == 2'd2) a = a & ~32'h3;
            end
        end
        txn(s, 1'($urandom % 2), a, $urandom, w, 1'($urandom % 2), $urandom % 3);
    endtask

    initial begin
        logic hold_ok;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_width = '0; req_sext = 1'b0; rsp_ready = 1'b0; sel = 0;
        repeat (3) @(negedge clk);
        check_val("reset_ready", 32'(ready2 | ready0), 32'h0);
        check_val("reset_valid", 32'(valid2 | valid0), 32'h0);
        check_val("reset_rdata", rd2 | rd0, 32'h0);
        check_val("reset_error", 32'(err2 | err0), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check_val("post_reset_ready", 32'(ready2 & ready0), 32'h1);

        for (int s = 0; s < 2; s++)
            for (int w = 0; w < 16; w++) txn(s, 1'b1, 32'(4 * w), $urandom, 2'd2, 1'b0, 0);

        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0);
        txn(0, 1'b1, 32'h13, 32'h0000005A, 2'd0, 1'b0, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0);
        txn(0, 1'b0, 32'h13, 32'h0, 2'd0, 1'b1, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 2'd1, 1'b1, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 2'd1, 1'b0, 0);
        check_val("merge_byte", {ref_mem[0][19], ref_mem[0][18], ref_mem[0][17], ref_mem[0][16]},
                  32'h5AADBEEF);
        txn(0, 1'b0, 32'h11, 32'h0, 2'd1, 1'b0, 0);
        txn(0, 1'b1, 32'h12, 32'h12345678, 2'd2, 1'b0, 0);
        txn(0, 1'b1, 32'h10, 32'h12345678, 2'd3, 1'b0, 0);
        txn(0, 1'b1, 32'h1000, 32'h12345678, 2'd2, 1'b0, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 5);

        // Reset during WAIT, held across the access edge: store must be lost.
        @(negedge clk);
        sel = 0; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h11111111;
        req_width = 2'd2; req_sext = 1'b0; rsp_ready = 1'b1; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_val("rst_wait_ready", 32'(o_ready), 32'h0);
        check_val("rst_wait_valid", 32'(o_valid), 32'h0);
        check_val("rst_wait_rdata", o_rdata, 32'h0);
        check_val("rst_wait_error", 32'(o_err), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        hold_ok = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (o_valid) hold_ok = 1'b0;
        end
        check_val("rst_no_rsp", 32'(hold_ok), 32'h1);
        rsp_ready = 1'b0;
        txn(0, 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 0);

        txn(1, 1'b1, 32'h24, 32'hCAFEF00D, 2'd2, 1'b0, 0);
        txn(1, 1'b0, 32'h24, 32'h0, 2'd2, 1'b0, 0);
        txn(1, 1'b0, 32'h26, 32'h0, 2'd1, 1'b1, 0);
        txn(1, 1'b0, 32'h25, 32'h0, 2'd2, 1'b0, 0);

        for (int i = 0; i < 150; i++) rand_txn(0);
        for (int i = 0; i < 150; i++) rand_txn(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
